// File: rtl/sync_mod_counter.sv
// sync_mod_counter
// Parametrised synchronous modulo-N up/down counter with parallel load,
// cascade carry chain, optional saturation, registered Gray output and a
// sticky overflow flag. Chain instances by wiring cout of the lower digit
// into cin of the next digit up.
module sync_mod_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cin,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             cout,
    output logic             ovf
);

    // Highest legal count value, and the modulus in one extra bit so that
    // MODULUS == 2^WIDTH is representable and the load clamp never fires.
    localparam logic [WIDTH-1:0] MAXCOUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODWIDE  = (WIDTH+1)'(MODULUS);

    logic             step;
    logic             atTop;
    logic             atBottom;
    logic [WIDTH-1:0] loadTarget;
    logic [WIDTH-1:0] nextCount;
    logic             nextOvf;

    // Boundary detection and the cascade qualifier. A stage only advances
    // when both its own enable and the carry from the stage below are high.
    always_comb begin
        step     = en & cin;
        atTop    = (count == MAXCOUNT);
        atBottom = (count == '0);
    end

    // Terminal count follows the current direction with no registered copy
    // of up_dn. The carry-out is suppressed during a load because a load
    // never produces a wrap, so the next stage must not advance with it.
    always_comb begin
        tc   = up_dn ? atTop : atBottom;
        cout = tc & en & cin & ~load;
    end

    // Load values at or beyond the modulus clamp to the top of the range.
    // load_val is only consumed inside the load branch of the next-state
    // logic, so an unknown load_val cannot leak into the count otherwise.
    always_comb begin
        loadTarget = load_val;
        if ({1'b0, load_val} >= MODWIDE) begin
            loadTarget = MAXCOUNT;
        end
    end

    // Next-state count and overflow. Load beats stepping; stepping at a
    // bound either wraps or holds depending on SATURATE, and in both cases
    // sets the sticky overflow flag, which only load or reset can clear.
    always_comb begin
        nextCount = count;
        nextOvf   = ovf;
        if (load) begin
            nextCount = loadTarget;
            nextOvf   = 1'b0;
        end else if (step) begin
            if (up_dn) begin
                if (atTop) begin
                    nextOvf   = 1'b1;
                    nextCount = SATURATE ? count : '0;
                end else begin
                    nextCount = count + 1'b1;
                end
            end else begin
                if (atBottom) begin
                    nextOvf   = 1'b1;
                    nextCount = SATURATE ? count : MAXCOUNT;
                end else begin
                    nextCount = count - 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset. Gray is encoded
    // from the next-state count so it changes on the same edge as count,
    // keeping gray == count ^ (count >> 1) true in every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            gray  <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= nextCount;
            gray  <= nextCount ^ (nextCount >> 1);
            ovf   <= nextOvf;
        end
    end

endmodule
